// File: rtl/oric_tap_loader.sv
// oric_tap_loader: streams an Oric .TAP image from the ioctl
// download bus into main RAM at the header's load address.
module oric_tap_loader #(
   parameter logic [7:0] TAP_INDEX = 8'd1,
   parameter int         MAX_NAME  = 16
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ram_we,
   output logic [15:0] ram_addr,
   output logic [7:0]  ram_din,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  tap_type,
   output logic        tap_autorun,
   output logic [15:0] tap_start,
   output logic [15:0] tap_end
);

   localparam int NW = $clog2(MAX_NAME + 1);
   localparam logic [NW-1:0] NAME_LIM = NW'(MAX_NAME);

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_HDR, S_NAME, S_DATA, S_DONE, S_ERR
   } state_t;

   state_t          state;
   logic            download_d;
   logic [1:0]      sync_cnt;
   logic [3:0]      hdr_idx;
   logic [NW-1:0]   name_cnt;
   logic [15:0]     ptr;
   logic            start;
   logic            fall;
   logic            acc;
   logic            last;
   logic            unused_addr;

   assign unused_addr = ^ioctl_addr;

   assign start = ioctl_download && !download_d
                  && (ioctl_index == TAP_INDEX);
   assign fall  = !ioctl_download && download_d;
   // a strobe coinciding with the falling edge still carries a byte
   assign acc   = ioctl_wr && busy && (ioctl_download || download_d);
   assign last  = acc && (state == S_DATA) && (ptr == tap_end);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state       <= S_IDLE;
         download_d  <= ioctl_download;
         sync_cnt    <= 2'd0;
         hdr_idx     <= 4'd0;
         name_cnt    <= '0;
         ptr         <= 16'd0;
         ram_we      <= 1'b0;
         ram_addr    <= 16'd0;
         ram_din     <= 8'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         tap_type    <= 8'd0;
         tap_autorun <= 1'b0;
         tap_start   <= 16'd0;
         tap_end     <= 16'd0;
      end else begin
         download_d <= ioctl_download;
         ram_we     <= 1'b0;
         if (start) begin
            state    <= S_SYNC;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            sync_cnt <= 2'd0;
            hdr_idx  <= 4'd0;
            name_cnt <= '0;
         end else begin
            if (acc) begin
               unique case (state)
                  S_SYNC: begin
                     if (ioctl_dout == 8'h16) begin
                        if (sync_cnt != 2'd3)
                           sync_cnt <= sync_cnt + 2'd1;
                     end else if (ioctl_dout == 8'h24) begin
                        if (sync_cnt == 2'd3) begin
                           state   <= S_HDR;
                           hdr_idx <= 4'd0;
                        end else begin
                           state <= S_ERR;
                           error <= 1'b1;
                           busy  <= 1'b0;
                        end
                     end else begin
                        sync_cnt <= 2'd0;
                     end
                  end
                  S_HDR: begin
                     hdr_idx <= hdr_idx + 4'd1;
                     case (hdr_idx)
                        4'd2: tap_type          <= ioctl_dout;
                        4'd3: tap_autorun       <= |ioctl_dout;
                        4'd4: tap_end[15:8]     <= ioctl_dout;
                        4'd5: tap_end[7:0]      <= ioctl_dout;
                        4'd6: tap_start[15:8]   <= ioctl_dout;
                        4'd7: tap_start[7:0]    <= ioctl_dout;
                        4'd8: begin
                           if (tap_start > tap_end) begin
                              state <= S_ERR;
                              error <= 1'b1;
                              busy  <= 1'b0;
                           end else begin
                              ptr      <= tap_start;
                              name_cnt <= '0;
                              state    <= S_NAME;
                           end
                        end
                        default: ;
                     endcase
                  end
                  S_NAME: begin
                     if (ioctl_dout == 8'h00) begin
                        state <= S_DATA;
                     end else if (name_cnt == NAME_LIM) begin
                        state <= S_ERR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                     end else begin
                        name_cnt <= name_cnt + NW'(1);
                     end
                  end
                  S_DATA: begin
                     ram_we   <= 1'b1;
                     ram_addr <= ptr;
                     ram_din  <= ioctl_dout;
                     ptr      <= ptr + 16'd1;
                     if (ptr == tap_end) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                     end
                  end
                  default: ;
               endcase
            end
            // truncation, unless the coincident byte finished the load
            if (fall && busy && !last) begin
               state <= S_ERR;
               error <= 1'b1;
               busy  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_oric_tap_loader.sv
// Bench for oric_tap_loader: table vectors, timed corner
// sequences and random TAP streams against a stream model.
module tb_oric_tap_loader;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'd0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = 25'd0;
   logic [7:0]  ioctl_dout = 8'd0;
   logic        ram_we;
   logic [15:0] ram_addr;
   logic [7:0]  ram_din;
   logic        busy, done, error, tap_autorun;
   logic [7:0]  tap_type;
   logic [15:0] tap_start, tap_end;

   int n_cmp = 0;
   int n_bad = 0;

   logic [23:0] wq[$];
   logic [23:0] ewq[$];
   logic [7:0]  st[$];
   bit          e_done, e_err;
   logic [7:0]  m_type;
   bit          m_auto;
   logic [15:0] m_start, m_end;

   typedef struct {
      int          garb;
      int          nsync;
      logic [15:0] a0;
      logic [15:0] a1;
      int          nlen;
      int          ndat;
      bit          xd;
      bit          xe;
      int          xw;
   } vec_t;

   vec_t vt[10];

   oric_tap_loader dut (
      .clk_sys(clk_sys), .reset(reset),
      .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_din(ram_din), .busy(busy),
      .done(done), .error(error), .tap_type(tap_type),
      .tap_autorun(tap_autorun), .tap_start(tap_start),
      .tap_end(tap_end)
   );

   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys)
      if (ram_we) wq.push_back({ram_addr, ram_din});

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int k);
      return 8'((k + 1) * 17);
   endfunction

   task automatic tick();
      @(negedge clk_sys);
   endtask

   task automatic dl_start(input logic [7:0] idx);
      ioctl_index = idx;
      ioctl_download = 1'b1;
      ioctl_addr = 25'd0;
      tick();
   endtask

   task automatic put(input logic [7:0] b);
      ioctl_wr = 1'b1;
      ioctl_dout = b;
      tick();
      ioctl_wr = 1'b0;
      ioctl_addr = ioctl_addr + 25'd1;
   endtask

   task automatic dl_end();
      ioctl_download = 1'b0;
      tick();
      tick();
   endtask

   task automatic run_stream();
      wq.delete();
      dl_start(8'd1);
      foreach (st[i]) put(st[i]);
      dl_end();
   endtask

   task automatic build(input vec_t v);
      st.delete();
      repeat (v.garb) st.push_back(8'hAA);
      repeat (v.nsync) st.push_back(8'h16);
      st.push_back(8'h24);
      st.push_back(8'h00);
      st.push_back(8'h00);
      st.push_back(8'h80);
      st.push_back(8'hC7);
      st.push_back(v.a1[15:8]);
      st.push_back(v.a1[7:0]);
      st.push_back(v.a0[15:8]);
      st.push_back(v.a0[7:0]);
      st.push_back(8'h00);
      for (int k = 0; k < v.nlen; k++) st.push_back(8'h41 + 8'(k));
      st.push_back(8'h00);
      for (int k = 0; k < v.ndat; k++) st.push_back(pat(k));
   endtask

   // Whole-stream reference: what a TAP reader does with this file.
   function automatic void model();
      int i, n, cnt, nl, len;
      logic [7:0] b;
      i = 0; n = st.size(); cnt = 0; nl = 0;
      e_done = 0; e_err = 0; ewq.delete();
      while (1) begin
         if (i >= n) begin e_err = 1; return; end
         b = st[i]; i++;
         if (b == 8'h24) begin
            if (cnt == 3) break;
            e_err = 1; return;
         end
         cnt = (b == 8'h16) ? ((cnt < 3) ? cnt + 1 : 3) : 0;
      end
      for (int k = 0; k < 9; k++) begin
         if (i >= n) begin e_err = 1; return; end
         b = st[i]; i++;
         case (k)
            2: m_type = b;
            3: m_auto = (b != 0);
            4: m_end[15:8] = b;
            5: m_end[7:0] = b;
            6: m_start[15:8] = b;
            7: m_start[7:0] = b;
            default: ;
         endcase
      end
      if (m_start > m_end) begin e_err = 1; return; end
      while (1) begin
         if (i >= n) begin e_err = 1; return; end
         b = st[i]; i++;
         if (b == 8'h00) break;
         if (nl == 16) begin e_err = 1; return; end
         nl++;
      end
      len = int'(m_end) - int'(m_start) + 1;
      for (int k = 0; k < len; k++) begin
         if (i >= n) begin e_err = 1; return; end
         ewq.push_back({m_start + 16'(k), st[i]});
         i++;
      end
      e_done = 1;
   endfunction

   task automatic cmp_model(input int c);
      chk($sformatf("r%0d.done", c), 32'(done), 32'(e_done));
      chk($sformatf("r%0d.error", c), 32'(error), 32'(e_err));
      chk($sformatf("r%0d.busy", c), 32'(busy), 32'd0);
      chk($sformatf("r%0d.nwr", c), wq.size(), ewq.size());
      foreach (ewq[i])
         if (i < wq.size())
            chk($sformatf("r%0d.wr%0d", c, i), 32'(wq[i]), 32'(ewq[i]));
      chk($sformatf("r%0d.type", c), 32'(tap_type), 32'(m_type));
      chk($sformatf("r%0d.auto", c), 32'(tap_autorun), 32'(m_auto));
      chk($sformatf("r%0d.start", c), 32'(tap_start), 32'(m_start));
      chk($sformatf("r%0d.end", c), 32'(tap_end), 32'(m_end));
   endtask

   task automatic chk_zero(input string t);
      chk({t, ".we"}, 32'(ram_we), 32'd0);
      chk({t, ".addr"}, 32'(ram_addr), 32'd0);
      chk({t, ".din"}, 32'(ram_din), 32'd0);
      chk({t, ".busy"}, 32'(busy), 32'd0);
      chk({t, ".done"}, 32'(done), 32'd0);
      chk({t, ".error"}, 32'(error), 32'd0);
      chk({t, ".type"}, 32'(tap_type), 32'd0);
      chk({t, ".auto"}, 32'(tap_autorun), 32'd0);
      chk({t, ".start"}, 32'(tap_start), 32'd0);
      chk({t, ".end"}, 32'(tap_end), 32'd0);
   endtask

   initial begin
      int n;
      vec_t v;
      logic [15:0] s0, ln;

      vt[0] = '{0, 3, 16'h5000, 16'h5003, 2, 4, 1, 0, 4};
      vt[1] = '{1, 3, 16'h5000, 16'h5003, 2, 4, 1, 0, 4};
      vt[2] = '{0, 2, 16'h5000, 16'h5003, 2, 4, 0, 1, 0};
      vt[3] = '{0, 3, 16'h6000, 16'h5FFF, 2, 4, 0, 1, 0};
      vt[4] = '{0, 3, 16'h5000, 16'h5003, 2, 2, 0, 1, 2};
      vt[5] = '{0, 3, 16'h1234, 16'h1234, 16, 1, 1, 0, 1};
      vt[6] = '{0, 3, 16'h1234, 16'h1234, 17, 1, 0, 1, 0};
      vt[7] = '{0, 3, 16'hFFFF, 16'hFFFF, 0, 1, 1, 0, 1};
      vt[8] = '{0, 3, 16'hFFFE, 16'hFFFF, 3, 5, 1, 0, 2};
      vt[9] = '{2, 5, 16'h0000, 16'h0007, 1, 8, 1, 0, 8};

      tick(); tick(); tick();
      chk_zero("rst");
      reset = 1'b0;
      tick();

      for (int t = 0; t < 10; t++) begin
         build(vt[t]);
         run_stream();
         chk($sformatf("v%0d.done", t), 32'(done), 32'(vt[t].xd));
         chk($sformatf("v%0d.error", t), 32'(error), 32'(vt[t].xe));
         chk($sformatf("v%0d.busy", t), 32'(busy), 32'd0);
         chk($sformatf("v%0d.nwr", t), wq.size(), vt[t].xw);
         for (int k = 0; k < vt[t].xw && k < wq.size(); k++)
            chk($sformatf("v%0d.wr%0d", t, k), 32'(wq[k]),
                32'({vt[t].a0 + 16'(k), pat(k)}));
      end

      // nominal load with per-byte write timing
      build(vt[0]);
      wq.delete();
      dl_start(8'd1);
      chk("nom.busy_rise", 32'(busy), 32'd1);
      n = st.size();
      for (int i = 0; i < n - 4; i++) put(st[i]);
      for (int k = 0; k < 4; k++) begin
         put(st[n - 4 + k]);
         chk($sformatf("nom.we%0d", k), 32'(ram_we), 32'd1);
         chk($sformatf("nom.addr%0d", k), 32'(ram_addr),
             32'(16'h5000 + 16'(k)));
         chk($sformatf("nom.din%0d", k), 32'(ram_din), 32'(pat(k)));
      end
      chk("nom.done", 32'(done), 32'd1);
      chk("nom.busy_fall", 32'(busy), 32'd0);
      tick();
      chk("nom.we_pulse", 32'(ram_we), 32'd0);
      chk("nom.type", 32'(tap_type), 32'h80);
      chk("nom.auto", 32'(tap_autorun), 32'd1);
      chk("nom.start", 32'(tap_start), 32'h5000);
      chk("nom.end", 32'(tap_end), 32'h5003);
      dl_end();

      // other-index download is ignored
      wq.delete();
      v = '{0, 3, 16'h7000, 16'h7001, 0, 2, 0, 0, 0};
      build(v);
      dl_start(8'd0);
      foreach (st[i]) put(st[i]);
      dl_end();
      chk("flt.done", 32'(done), 32'd1);
      chk("flt.error", 32'(error), 32'd0);
      chk("flt.start", 32'(tap_start), 32'h5000);
      chk("flt.nwr", wq.size(), 0);

      // back-to-back TAP: done clears at start
      wq.delete();
      v = '{0, 3, 16'h0300, 16'h0301, 0, 2, 0, 0, 0};
      build(v);
      dl_start(8'd1);
      chk("rs.done_clr", 32'(done), 32'd0);
      chk("rs.busy", 32'(busy), 32'd1);
      foreach (st[i]) put(st[i]);
      dl_end();
      chk("rs.done", 32'(done), 32'd1);
      chk("rs.nwr", wq.size(), 2);
      if (wq.size() > 0) chk("rs.wr0", 32'(wq[0]), 32'h030011);

      // truncation timing
      wq.delete();
      build(vt[0]);
      dl_start(8'd1);
      for (int i = 0; i < st.size() - 2; i++) put(st[i]);
      ioctl_download = 1'b0;
      tick();
      chk("tr.error", 32'(error), 32'd1);
      chk("tr.busy", 32'(busy), 32'd0);
      tick();
      chk("tr.nwr", wq.size(), 2);

      // reset in the middle of DATA
      wq.delete();
      build(vt[0]);
      dl_start(8'd1);
      for (int i = 0; i < st.size() - 2; i++) put(st[i]);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_zero("mrst");
      put(st[st.size() - 2]);
      put(st[st.size() - 1]);
      chk("mrst.we", 32'(ram_we), 32'd0);
      chk("mrst.nwr", wq.size(), 2);
      dl_end();
      chk("mrst.error", 32'(error), 32'd0);

      // last data byte together with the falling edge
      wq.delete();
      v = '{0, 3, 16'h4000, 16'h4000, 0, 1, 0, 0, 0};
      build(v);
      dl_start(8'd1);
      for (int i = 0; i < st.size() - 1; i++) put(st[i]);
      ioctl_download = 1'b0;
      ioctl_wr = 1'b1;
      ioctl_dout = st[st.size() - 1];
      tick();
      ioctl_wr = 1'b0;
      chk("fe.done", 32'(done), 32'd1);
      chk("fe.error", 32'(error), 32'd0);
      chk("fe.we", 32'(ram_we), 32'd1);
      chk("fe.addr", 32'(ram_addr), 32'h4000);
      chk("fe.din", 32'(ram_din), 32'h11);
      tick(); tick();

      // strobe on the start edge is dropped
      wq.delete();
      ioctl_index = 8'd1;
      ioctl_download = 1'b1;
      ioctl_wr = 1'b1;
      ioctl_dout = 8'h16;
      tick();
      ioctl_wr = 1'b0;
      put(8'h16); put(8'h16); put(8'h24);
      chk("se.error", 32'(error), 32'd1);
      chk("se.busy", 32'(busy), 32'd0);
      dl_end();
      chk("se.nwr", wq.size(), 0);

      // random streams against the model
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_type = 0; m_auto = 0; m_start = 0; m_end = 0;
      tick();
      for (int c = 0; c < 40; c++) begin
         st.delete();
         repeat ($urandom_range(0, 3)) begin
            logic [7:0] g;
            g = 8'($urandom);
            if (g == 8'h24) g = 8'h25;
            st.push_back(g);
         end
         repeat ($urandom_range(1, 5)) st.push_back(8'h16);
         st.push_back(8'h24);
         s0 = 16'($urandom);
         ln = 16'($urandom_range(1, 6));
         st.push_back(8'($urandom));
         st.push_back(8'($urandom));
         st.push_back(8'($urandom));
         st.push_back(($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00);
         ln = ($urandom_range(0, 7) == 0) ? 16'hFFFF : ln;
         st.push_back(8'((s0 + ln - 16'd1) >> 8));
         st.push_back(8'(s0 + ln - 16'd1));
         st.push_back(s0[15:8]);
         st.push_back(s0[7:0]);
         st.push_back(8'($urandom));
         repeat ($urandom_range(0, 17))
            st.push_back(8'($urandom_range(1, 255)));
         st.push_back(8'h00);
         repeat (8) st.push_back(8'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            n = $urandom_range(1, st.size());
            while (st.size() > n) void'(st.pop_back());
         end
         model();
         run_stream();
         cmp_model(c);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
